// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: fetches sequential words ahead of the core
// into a DEPTH-entry {pc, data} FIFO over a req/ack memory handshake.
// A redirect flushes the FIFO; a fetch already in flight is drained and its
// data dropped before the new target is requested.
// Optional feature macro: PREFETCH_BYPASS_EN. When defined, a word returning
// into an empty FIFO is presented to the core in the same cycle.
module instr_prefetch #(
    parameter int unsigned        DEPTH    = 4,
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              nReset,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectAddr,
    output logic              InstrValid,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] InstrPC,
    input  logic              InstrTake
);

    localparam int unsigned       PTR_W      = $clog2(DEPTH);
    localparam int unsigned       CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL       = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ONE        = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [ADDR_W-1:0] WORD       = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_q, fetch_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                req_d;

    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q, rd_ptr_inc;
    logic [ADDR_W-1:0]   pc_mem   [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];

    logic                valid_q;
    logic [DATA_W-1:0]   instr_q, head_instr_d;
    logic [ADDR_W-1:0]   pc_q, head_pc_d;

    logic [ADDR_W-1:0]   redir_addr;
    logic                push, pop, bypass_take;

`ifdef PREFETCH_BYPASS_EN
    logic                bypass_hit;

    // Word returning into an empty FIFO is visible to the core this cycle
    assign bypass_hit = (state_q == S_REQ) && MemAck && !Redirect && (count_q == '0);
    assign InstrValid = valid_q | bypass_hit;
    assign Instr      = bypass_hit ? MemRData : instr_q;
    assign InstrPC    = bypass_hit ? MemAddr  : pc_q;
`else
    assign InstrValid = valid_q;
    assign Instr      = instr_q;
    assign InstrPC    = pc_q;
`endif

    // FIFO push/pop qualification and occupancy update
    always_comb begin
        redir_addr  = RedirectAddr & ALIGN_MASK;
        rd_ptr_inc  = rd_ptr_q + PTR_ONE;
        pop         = (count_q != '0) && InstrTake && !Redirect;
`ifdef PREFETCH_BYPASS_EN
        bypass_take = bypass_hit && InstrTake;
`else
        bypass_take = 1'b0;
`endif
        push        = (state_q == S_REQ) && MemAck && !Redirect && !bypass_take;
        if (Redirect) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Fetch FSM next state, fetch address and registered request outputs
    always_comb begin
        state_d  = state_q;
        fetch_d  = fetch_q;
        target_d = target_q;
        addr_d   = MemAddr;
        case (state_q)
            S_IDLE: begin
                if (Redirect) begin
                    state_d  = S_REQ;
                    fetch_d  = redir_addr;
                    target_d = redir_addr;
                    addr_d   = redir_addr;
                end else if (count_q < FULL) begin
                    state_d = S_REQ;
                    addr_d  = fetch_q;
                end
            end
            S_REQ: begin
                if (Redirect) begin
                    target_d = redir_addr;
                    if (MemAck) begin
                        fetch_d = redir_addr;
                        addr_d  = redir_addr;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (MemAck) begin
                    fetch_d = fetch_q + WORD;
                    if (count_d < FULL) begin
                        addr_d = fetch_q + WORD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (Redirect) begin
                    target_d = redir_addr;
                    // Old request completes now, so the newest target can go out directly
                    if (MemAck) begin
                        state_d = S_REQ;
                        fetch_d = redir_addr;
                        addr_d  = redir_addr;
                    end
                end else if (MemAck) begin
                    state_d = S_REQ;
                    fetch_d = target_q;
                    addr_d  = target_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_d = (state_d != S_IDLE);
    end

    // Next head entry for the registered core-side outputs
    always_comb begin
        head_instr_d = instr_q;
        head_pc_d    = pc_q;
        if (!Redirect) begin
            if (pop && (count_q > ONE)) begin
                head_instr_d = data_mem[rd_ptr_inc];
                head_pc_d    = pc_mem[rd_ptr_inc];
            end else if (push && ((count_q == '0) || (pop && (count_q == ONE)))) begin
                head_instr_d = MemRData;
                head_pc_d    = fetch_q;
            end
        end
    end

    // FSM state, fetch address and memory-side output registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            fetch_q  <= RESET_PC;
            target_q <= '0;
            MemReq   <= 1'b0;
            MemAddr  <= '0;
        end else begin
            state_q  <= state_d;
            fetch_q  <= fetch_d;
            target_q <= target_d;
            MemReq   <= req_d;
            MemAddr  <= addr_d;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (Redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_inc;
            end
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count
    always_ff @(posedge Clock) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_q;
            data_mem[wr_ptr_q] <= MemRData;
        end
    end

    // Registered head outputs; head data holds its last value when empty
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= (count_d != '0);
            instr_q <= head_instr_d;
            pc_q    <= head_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_instr_prefetch;

    localparam int unsigned DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        Clock;
    logic        nReset;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemRData;
    logic        Redirect;
    logic [15:0] RedirectAddr;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [15:0] InstrPC;
    logic        InstrTake;

    instr_prefetch #(
        .DEPTH   (DEPTH),
        .ADDR_W  (16),
        .DATA_W  (32),
        .RESET_PC(RESET_PC)
    ) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .MemReq      (MemReq),
        .MemAddr     (MemAddr),
        .MemAck      (MemAck),
        .MemRData    (MemRData),
        .Redirect    (Redirect),
        .RedirectAddr(RedirectAddr),
        .InstrValid  (InstrValid),
        .Instr       (Instr),
        .InstrPC     (InstrPC),
        .InstrTake   (InstrTake)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] data;
    } entry_t;

    // Reference model: fetched-but-unconsumed words, fetch pointer, mode
    entry_t      mq[$];
    int          m_mode;    // 0: no request, 1: requesting, 2: draining stale request
    logic [15:0] m_fetch;
    logic [15:0] m_tgt;
    logic [15:0] m_addr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode  = 0;
        m_fetch = RESET_PC;
        m_tgt   = 16'h0000;
        m_addr  = 16'h0000;
    endtask

    task automatic model_step(input logic ack, input logic take, input logic redir,
                              input logic [15:0] raddr, input logic [31:0] rdata);
        int          occ;
        logic [15:0] al;
        entry_t      e;
        occ = mq.size();
        al  = raddr & 16'hFFFC;
        if (redir) begin
            mq.delete();
            m_tgt = al;
            if (m_mode == 0 || ack) begin
                m_mode  = 1;
                m_fetch = al;
                m_addr  = al;
            end else begin
                m_mode = 2;
            end
        end else begin
            if (occ != 0 && take) void'(mq.pop_front());
            if (m_mode == 0) begin
                if (occ < DEPTH) begin
                    m_mode = 1;
                    m_addr = m_fetch;
                end
            end else if (m_mode == 1) begin
                if (ack) begin
                    e.pc   = m_fetch;
                    e.data = rdata;
                    mq.push_back(e);
                    m_fetch = m_fetch + 16'd4;
                    if (mq.size() < DEPTH) m_addr = m_fetch;
                    else m_mode = 0;
                end
            end else begin
                if (ack) begin
                    m_mode  = 1;
                    m_fetch = m_tgt;
                    m_addr  = m_tgt;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " MemReq"}, 32'(MemReq), 32'(m_mode != 0));
        if (m_mode != 0) chk({tag, " MemAddr"}, 32'(MemAddr), 32'(m_addr));
        chk({tag, " InstrValid"}, 32'(InstrValid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk({tag, " InstrPC"}, 32'(InstrPC), 32'(mq[0].pc));
            chk({tag, " Instr"}, Instr, mq[0].data);
        end
    endtask

    // One clock: drive inputs just after the falling edge, check on the next one
    task automatic step(input string tag, input logic ack, input logic take,
                        input logic redir, input logic [15:0] raddr);
        logic        a;
        logic [31:0] d;
        a = ack && (m_mode != 0);
        d = $urandom;
        MemAck       = a;
        MemRData     = d;
        InstrTake    = take;
        Redirect     = redir;
        RedirectAddr = raddr;
        model_step(a, take, redir, raddr, d);
        @(posedge Clock);
        @(negedge Clock);
        check_outputs(tag);
    endtask

    logic [15:0] wrap_exp [4];

    initial begin
        wrap_exp[0] = 16'hFFFC;
        wrap_exp[1] = 16'h0000;
        wrap_exp[2] = 16'h0004;
        wrap_exp[3] = 16'h0008;

        nReset       = 1'b0;
        MemAck       = 1'b0;
        MemRData     = 32'h0;
        Redirect     = 1'b0;
        RedirectAddr = 16'h0;
        InstrTake    = 1'b0;
        model_reset();

        // Reset values
        @(negedge Clock);
        chk("rst MemReq", 32'(MemReq), 32'h0);
        chk("rst MemAddr", 32'(MemAddr), 32'h0);
        chk("rst InstrValid", 32'(InstrValid), 32'h0);
        chk("rst Instr", Instr, 32'h0);
        chk("rst InstrPC", 32'(InstrPC), 32'h0);

        // Startup: zero-wait memory, core always taking
        nReset = 1'b1;
        step("start", 1'b0, 1'b1, 1'b0, 16'h0);
        chk("start first req", 32'(MemReq), 32'h1);
        chk("start first addr", 32'(MemAddr), 32'(RESET_PC));
        for (int i = 0; i < 8; i++) step("start", 1'b1, 1'b1, 1'b0, 16'h0);

        // Fill: no takes, restart at 0 via redirect
        step("full", 1'b0, 1'b0, 1'b1, 16'h0000);
        step("full", 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) step("full", 1'b1, 1'b0, 1'b0, 16'h0);
        chk("full stop req", 32'(MemReq), 32'h0);
        chk("full head pc", 32'(InstrPC), 32'h0);
        step("full take", 1'b0, 1'b1, 1'b0, 16'h0);
        chk("full take head", 32'(InstrPC), 32'h4);
        step("full refill", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("full refill req", 32'(MemReq), 32'h1);
        chk("full refill addr", 32'(MemAddr), 32'h10);
        step("full refill", 1'b1, 1'b0, 1'b0, 16'h0);
        step("full again", 1'b1, 1'b0, 1'b0, 16'h0);
        chk("full again req", 32'(MemReq), 32'h0);
        for (int i = 0; i < 4; i++) step("full drain", 1'b0, 1'b1, 1'b0, 16'h0);

        // Redirect while a fetch of 0x8 is pending, ack delayed
        step("pend setup", 1'b1, 1'b0, 1'b1, 16'h0008);
        chk("pend setup addr", 32'(MemAddr), 32'h8);
        step("pend redir", 1'b0, 1'b0, 1'b1, 16'h0103);
        chk("pend hold addr", 32'(MemAddr), 32'h8);
        chk("pend hold req", 32'(MemReq), 32'h1);
        for (int i = 0; i < 2; i++) begin
            step("pend wait", 1'b0, 1'b1, 1'b0, 16'h0);
            chk("pend wait addr", 32'(MemAddr), 32'h8);
        end
        step("pend ack", 1'b1, 1'b1, 1'b0, 16'h0);
        chk("pend new addr", 32'(MemAddr), 32'h0100);
        chk("pend no valid", 32'(InstrValid), 32'h0);
        for (int i = 0; i < 2; i++) step("pend gap", 1'b0, 1'b1, 1'b0, 16'h0);
        chk("pend still empty", 32'(InstrValid), 32'h0);
        step("pend ret", 1'b1, 1'b1, 1'b0, 16'h0);
        chk("pend first pc", 32'(InstrPC), 32'h0100);

        // Redirect + ack + take together with two entries queued
        step("simul fill", 1'b1, 1'b0, 1'b0, 16'h0);
        chk("simul two", 32'(mq.size()), 32'h2);
        step("simul", 1'b1, 1'b1, 1'b1, 16'h0040);
        chk("simul empty", 32'(InstrValid), 32'h0);
        chk("simul addr", 32'(MemAddr), 32'h40);
        chk("simul req", 32'(MemReq), 32'h1);

        // Address wrap past 0xFFFC
        step("wrap redir", 1'b1, 1'b1, 1'b1, 16'hFFF8);
        chk("wrap start", 32'(MemAddr), 32'hFFF8);
        for (int i = 0; i < 4; i++) begin
            step("wrap", 1'b1, 1'b1, 1'b0, 16'h0);
            chk("wrap seq", 32'(MemAddr), 32'(wrap_exp[i]));
        end

        // Asynchronous reset in the middle of a request
        chk("arst pre req", 32'(MemReq), 32'h1);
        #2;
        nReset = 1'b0;
        MemAck = 1'b1;
        #1;
        chk("arst MemReq", 32'(MemReq), 32'h0);
        chk("arst InstrValid", 32'(InstrValid), 32'h0);
        chk("arst MemAddr", 32'(MemAddr), 32'h0);
        model_reset();
        @(posedge Clock);
        @(negedge Clock);
        chk("arst held req", 32'(MemReq), 32'h0);
        chk("arst held valid", 32'(InstrValid), 32'h0);
        nReset = 1'b1;
        step("arst restart", 1'b0, 1'b1, 1'b0, 16'h0);
        chk("arst restart addr", 32'(MemAddr), 32'(RESET_PC));
        for (int i = 0; i < 4; i++) step("arst run", 1'b1, 1'b1, 1'b0, 16'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 19) == 0),
                 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
